// File: rtl/mem_acc_pkg.sv
// mem_acc_pkg: shared definitions for the MEM-stage data-memory access unit.
//   - size encodings for load/store width
//   - FSM state encoding
//   - misaligned(): decides whether a request must go to FAULT
package mem_acc_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    // The reserved size is treated as a fault together with true misalignment,
    // so one test covers every request that must not touch memory.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane.sv
// mem_lane: combinational little-endian lane logic for a 32-bit memory word.
// Ports:
//   word_i   : word read from memory
//   wdata_i  : right-justified store data
//   size_i   : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   signed_i : sign-extend sub-word loads
//   off_i    : byte offset within the word (addr[1:0])
//   ext_o    : addressed lane(s) extracted and extended to 32 bits
//   merged_o : word_i with the addressed lane(s) replaced by wdata_i low bits
module mem_lane
    import mem_acc_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  off_i,
    output logic [31:0] ext_o,
    output logic [31:0] merged_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;

    // Byte lane k sits at bits [8k+7:8k]; half lane h at [16h+15:16h].
    assign byte_sh   = {off_i, 3'b000};
    assign half_sh   = {off_i[1], 4'b0000};
    assign byte_v    = 8'(word_i >> byte_sh);
    assign half_v    = 16'(word_i >> half_sh);
    assign byte_mask = 32'h0000_00FF << byte_sh;
    assign half_mask = 32'h0000_FFFF << half_sh;

    always_comb begin
        ext_o    = word_i;
        merged_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                ext_o    = signed_i ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
                merged_o = (word_i & ~byte_mask) | ((32'(wdata_i[7:0]) << byte_sh) & byte_mask);
            end
            SZ_HALF: begin
                ext_o    = signed_i ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
                merged_o = (word_i & ~half_mask) | ((32'(wdata_i[15:0]) << half_sh) & half_mask);
            end
            default: begin
                ext_o    = word_i;
                merged_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for the word-wide, byte-addressed,
// little-endian data memory. Converts one load/store request into aligned
// mrd/mwr cycles; sub-word stores use read-modify-write.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake (ready == idle)
//   req_wr, req_size, req_signed, req_addr, req_wdata : request fields
//   rsp_valid, rsp_rdata, rsp_err : one-cycle completion pulse and result
//   busy                     : unit not idle (pipeline stall)
//   mem_adr, mem_din, mem_rd, mem_wr, mem_dout : memory port
module mem_access_unit
    import mem_acc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_dout
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [31:0]       ext_w;
    logic [31:0]       merged_w;

    mem_lane u_lane (
        .word_i   (mem_dout),
        .wdata_i  (buf_q),
        .size_i   (size_q),
        .signed_i (signed_q),
        .off_i    (addr_q[1:0]),
        .ext_o    (ext_w),
        .merged_o (merged_w)
    );

    // The store/load direction is not kept: it is fully encoded in the
    // state chosen at accept time.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        buf_d    = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    size_d   = req_size;
                    signed_d = req_signed;
                    if (req_wr) buf_d = req_wdata;
                    if (misaligned(req_size, req_addr[1:0])) state_d = ST_FAULT;
                    else if (!req_wr)                         state_d = ST_LOAD;
                    else if (req_size == SZ_WORD)             state_d = ST_WRITE;
                    else                                      state_d = ST_RMW_RD;
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            ST_RMW_RD: begin
                // Buffer holds the store data until here; replace it with the merged word.
                buf_d   = merged_w;
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            buf_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            buf_q       <= buf_d;
            // Response is a registered pulse that lines up with the return to IDLE.
            rsp_valid_q <= (state_q == ST_LOAD) || (state_q == ST_WRITE) || (state_q == ST_FAULT);
            rsp_err_q   <= (state_q == ST_FAULT);
            rdata_q     <= (state_q == ST_LOAD) ? ext_w : '0;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rdata_q;

    assign mem_rd  = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
    // A reset landing on the write cycle must not corrupt memory.
    assign mem_wr  = (state_q == ST_WRITE) && !rst;
    assign mem_din = mem_wr ? buf_q : '0;
    assign mem_adr = mem_rd || (state_q == ST_WRITE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [31:0] mem_adr;
    logic [31:0] mem_din;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_dout;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .mem_adr    (mem_adr),
        .mem_din    (mem_din),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_dout   (mem_dout)
    );

    // Memory model (1 KiB) and the reference image the bench predicts.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic        load_mem;

    assign mem_dout = mem[mem_adr[9:2]];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (mem_wr) begin
            mem[mem_adr[9:2]] <= mem_din;
        end
    end

    typedef struct {
        bit          wr;
        logic [1:0]  size;
        bit          sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] e_rdata;
        bit          e_err;
        int          e_rd;
        int          e_wr;
        int          e_rsp;
        logic [31:0] e_din;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference model: works on byte arrays, updates ref_mem for accepted stores.
    task automatic model(inout vec_t v);
        logic [7:0]  b [4];
        logic [31:0] val;
        int n, off, idx;
        n   = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        off = int'(v.addr[1:0]);
        idx = int'(v.addr[9:2]);
        v.e_err   = (v.size == 2'd3) || ((off % n) != 0);
        v.e_rdata = 32'h0;
        v.e_din   = 32'h0;
        v.e_rd    = 0;
        v.e_wr    = 0;
        v.e_rsp   = 2;
        if (v.e_err) return;
        for (int k = 0; k < 4; k++) b[k] = ref_mem[idx][8*k +: 8];
        if (!v.wr) begin
            val = 32'h0;
            for (int j = 0; j < n; j++) val = val | (32'(b[off+j]) << (8*j));
            if (v.sgn && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
            v.e_rdata = val;
            v.e_rd    = 1;
        end else begin
            if (n < 4) begin
                v.e_rd  = 1;
                v.e_wr  = 2;
                v.e_rsp = 3;
            end else begin
                v.e_wr = 1;
            end
            for (int j = 0; j < n; j++) b[off+j] = v.wdata[8*j +: 8];
            val          = {b[3], b[2], b[1], b[0]};
            ref_mem[idx] = val;
            v.e_din      = val;
        end
    endtask

    // Issue one request at the current negedge and observe it cycle by cycle.
    // Returns at the negedge of the response cycle so the next call is back-to-back.
    task automatic run_req(input vec_t v, input string nm);
        int rd_c, wr_c, rsp_c;
        logic [31:0] rdata, din, adr_rd, adr_wr, e_adr;
        logic err;
        bit proto;
        rd_c = 0; wr_c = 0; rsp_c = 0;
        rdata = 32'h0; din = 32'h0; adr_rd = 32'h0; adr_wr = 32'h0; err = 1'b0;
        proto = 1'b1;
        e_adr = {v.addr[31:2], 2'b00};
        chk({nm, ".ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_wr     = v.wr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1;
        // Junk on the request lines while busy must be ignored.
        req_wr     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = 32'($urandom_range(0, 1023));
        req_wdata  = $urandom;
        for (int c = 1; c <= 6 && rsp_c == 0; c++) begin
            @(negedge clk);
            if (c == 1 && (!busy || req_ready)) proto = 1'b0;
            if (mem_rd && mem_wr) proto = 1'b0;
            if (!mem_wr && mem_din != 32'h0) proto = 1'b0;
            if (!rsp_valid && (rsp_rdata != 32'h0 || rsp_err)) proto = 1'b0;
            if (mem_adr[31:10] != 22'h0) proto = 1'b0;
            if (mem_rd) begin
                if (rd_c == 0) rd_c = c; else proto = 1'b0;
                adr_rd = mem_adr;
            end
            if (mem_wr) begin
                if (wr_c == 0) wr_c = c; else proto = 1'b0;
                adr_wr = mem_adr;
                din    = mem_din;
            end
            if (rsp_valid) begin
                rsp_c = c;
                rdata = rsp_rdata;
                err   = rsp_err;
            end
        end
        req_valid = 1'b0;
        chk({nm, ".rsp_cycle"}, 32'(rsp_c), 32'(v.e_rsp));
        chk({nm, ".rdata"},     rdata,      v.e_rdata);
        chk({nm, ".err"},       32'(err),   32'(v.e_err));
        chk({nm, ".rd_cycle"},  32'(rd_c),  32'(v.e_rd));
        chk({nm, ".wr_cycle"},  32'(wr_c),  32'(v.e_wr));
        chk({nm, ".protocol"},  32'(proto), 32'd1);
        if (v.e_rd != 0) chk({nm, ".rd_adr"}, adr_rd, e_adr);
        if (v.e_wr != 0) begin
            chk({nm, ".wr_adr"}, adr_wr, e_adr);
            chk({nm, ".din"},    din,    v.e_din);
        end
    endtask

    vec_t tbl [12];
    vec_t tmp;

    initial begin
        rst        = 1'b1;
        load_mem   = 1'b1;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        ref_mem[32'h100 >> 2] = 32'h8899AABB;
        ref_mem[32'h108 >> 2] = 32'h8899AABB;
        ref_mem[32'h10C >> 2] = 32'h01020304;

        //                 wr size   sgn addr       wdata          e_rdata       err rd wr rsp e_din
        tbl[0]  = '{1'b0, 2'b00, 1'b1, 32'h101, 32'h0,        32'hFFFFFFAA, 1'b0, 1, 0, 2, 32'h0};
        tbl[1]  = '{1'b0, 2'b00, 1'b0, 32'h101, 32'h0,        32'h000000AA, 1'b0, 1, 0, 2, 32'h0};
        tbl[2]  = '{1'b0, 2'b01, 1'b1, 32'h102, 32'h0,        32'hFFFF8899, 1'b0, 1, 0, 2, 32'h0};
        tbl[3]  = '{1'b0, 2'b01, 1'b0, 32'h100, 32'h0,        32'h0000AABB, 1'b0, 1, 0, 2, 32'h0};
        tbl[4]  = '{1'b0, 2'b10, 1'b1, 32'h100, 32'h0,        32'h8899AABB, 1'b0, 1, 0, 2, 32'h0};
        tbl[5]  = '{1'b1, 2'b00, 1'b0, 32'h103, 32'h11,       32'h0,        1'b0, 1, 2, 3, 32'h1199AABB};
        tbl[6]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h1199AABB, 1'b0, 1, 0, 2, 32'h0};
        tbl[7]  = '{1'b1, 2'b01, 1'b0, 32'h108, 32'h2233,     32'h0,        1'b0, 1, 2, 3, 32'h88992233};
        tbl[8]  = '{1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 32'h0,        1'b0, 0, 1, 2, 32'hDEADBEEF};
        tbl[9]  = '{1'b1, 2'b01, 1'b0, 32'h101, 32'hCAFE,     32'h0,        1'b1, 0, 0, 2, 32'h0};
        tbl[10] = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h0,        32'h0,        1'b1, 0, 0, 2, 32'h0};
        tbl[11] = '{1'b1, 2'b11, 1'b0, 32'h100, 32'h12345678, 32'h0,        1'b1, 0, 0, 2, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.req_ready", 32'(req_ready), 32'd1);
        chk("reset.busy",      32'(busy),      32'd0);
        chk("reset.strobes",   {30'h0, mem_rd, mem_wr}, 32'h0);
        chk("reset.rsp",       {31'h0, rsp_valid} | 32'(rsp_err), 32'h0);
        chk("reset.rsp_rdata", rsp_rdata, 32'h0);
        chk("reset.mem_adr",   mem_adr,   32'h0);
        chk("reset.mem_din",   mem_din,   32'h0);
        load_mem = 1'b0;
        rst      = 1'b0;
        @(negedge clk);

        // Directed vectors, issued back-to-back.
        for (int i = 0; i < 12; i++) begin
            tmp = tbl[i];
            model(tmp);
            run_req(tbl[i], $sformatf("tbl%0d", i));
        end

        // Reset during the WRITE cycle of a byte store aborts it.
        req_valid  = 1'b1;
        req_wr     = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h10C;
        req_wdata  = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort.rd_c1", 32'(mem_rd), 32'd1);
        @(negedge clk);
        chk("abort.wr_c2", 32'(mem_wr), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort.wr_suppressed", 32'(mem_wr), 32'd0);
        chk("abort.din_zero",      mem_din,     32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort.no_rsp",    32'(rsp_valid), 32'd0);
        chk("abort.req_ready", 32'(req_ready), 32'd1);
        chk("abort.mem_kept",  mem[32'h10C >> 2], 32'h01020304);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 200; i++) begin
            tmp.wr    = 1'($urandom);
            tmp.size  = 2'($urandom);
            tmp.sgn   = 1'($urandom);
            tmp.addr  = 32'($urandom_range(0, 1023));
            tmp.wdata = $urandom;
            model(tmp);
            run_req(tmp, $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        for (int i = 0; i < 256; i++) chk($sformatf("memword%0d", i), mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
